// File: rtl/piece_queue_gen_if.sv
// Piece queue generator handshake bundle.
// Consumer side drives take/seed; generator side drives queue view.
interface piece_queue_gen_if #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 3
);
   logic                     take;
   logic                     seed_we;
   logic [WIDTH-1:0]         seed_in;
   logic [WIDTH-1:0]         piece;
   logic                     valid;
   logic [DEPTH*WIDTH-1:0]   preview;
   logic [3:0]               count;

   modport master (
      output take, seed_we, seed_in,
      input  piece, valid, preview, count
   );

   modport slave (
      input  take, seed_we, seed_in,
      output piece, valid, preview, count
   );
endinterface

// File: rtl/piece_queue_gen.sv
// LFSR-driven symbol generator feeding a small preview queue.
// Out-of-range candidates are skipped; the queue back-pressures the LFSR.
module piece_queue_gen #(
   parameter int               WIDTH       = 3,
   parameter logic [WIDTH-1:0] TAPS        = 3'b110,
   parameter logic [WIDTH-1:0] SEED        = 3'b101,
   parameter int               DEPTH       = 3,
   parameter int               NUM_SYMBOLS = 7
) (
   input logic              Clk,
   input logic              reset_n,
   piece_queue_gen_if.slave bus
);

   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] q_q [DEPTH];
   logic [WIDTH-1:0] q_d [DEPTH];
   logic [3:0]       count_q, count_d;

   logic [WIDTH-1:0] cand;
   logic [WIDTH-1:0] s_next;
   logic [3:0]       tail;
   logic             accept;
   logic             pop;
   logic             space;
   logic             push;

   assign cand   = s_q - WIDTH'(1);
   assign accept = cand < WIDTH'(NUM_SYMBOLS);
   assign s_next = {s_q[WIDTH-2:0], ^(s_q & TAPS)};
   assign pop    = bus.take & (count_q != 4'd0);
   assign space  = (count_q < 4'(DEPTH)) | pop;
   // A zero state never yields a push; it only reloads SEED.
   assign push   = (s_q != '0) & accept & space;
   assign tail   = count_q - {3'b000, pop};

   always_comb begin
      s_d     = s_q;
      q_d     = q_q;
      count_d = count_q;
      if (bus.seed_we) begin
         s_d     = (bus.seed_in == '0) ? SEED : bus.seed_in;
         count_d = 4'd0;
         for (int i = 0; i < DEPTH; i++) q_d[i] = '0;
      end else begin
         if (s_q == '0)          s_d = SEED;
         else if (!accept)       s_d = s_next;
         else if (space)         s_d = s_next;
         if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) q_d[i] = q_q[i+1];
            q_d[DEPTH-1] = '0;
         end
         for (int i = 0; i < DEPTH; i++)
            if (push && tail == 4'(i)) q_d[i] = cand;
         count_d = count_q + {3'b000, push} - {3'b000, pop};
      end
   end

   always_ff @(posedge Clk) begin
      if (!reset_n) begin
         s_q     <= SEED;
         count_q <= 4'd0;
         for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
      end else begin
         s_q     <= s_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) q_q[i] <= q_d[i];
      end
   end

   always_comb begin
      bus.preview = '0;
      for (int i = 0; i < DEPTH; i++)
         bus.preview[i*WIDTH +: WIDTH] = q_q[i];
   end

   assign bus.piece = q_q[0];
   assign bus.valid = (count_q != 4'd0);
   assign bus.count = count_q;

endmodule

// File: tb/tb_piece_queue_gen.sv
// Directed bench for piece_queue_gen: default build plus a
// five-symbol build sharing clock and reset.
module tb_piece_queue_gen;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   piece_queue_gen_if #(.WIDTH(3), .DEPTH(3)) bus ();
   piece_queue_gen_if #(.WIDTH(3), .DEPTH(3)) bus5 ();

   piece_queue_gen u_dut (
      .Clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   piece_queue_gen #(.NUM_SYMBOLS(5)) u_dut5 (
      .Clk     (clk),
      .reset_n (reset_n),
      .bus     (bus5)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int seq_take [8] = '{2, 6, 5, 3, 0, 1, 4, 2};
   int cnt5     [5] = '{1, 2, 2, 2, 3};

   initial begin
      reset_n      = 1'b0;
      bus.take     = 1'b0;
      bus.seed_we  = 1'b0;
      bus.seed_in  = '0;
      bus5.take    = 1'b0;
      bus5.seed_we = 1'b0;
      bus5.seed_in = '0;
      tick();
      tick();
      chk("rst_count",   32'(bus.count),   0);
      chk("rst_valid",   32'(bus.valid),   0);
      chk("rst_piece",   32'(bus.piece),   0);
      chk("rst_preview", 32'(bus.preview), 0);

      reset_n = 1'b1;
      for (int e = 0; e < 5; e++) begin
         tick();
         chk("fill_count",  32'(bus.count),  (e < 3) ? e + 1 : 3);
         chk("skip_count",  32'(bus5.count), cnt5[e]);
      end
      chk("fill_preview", 32'(bus.preview), 32'(9'b110_010_100));
      chk("fill_piece",   32'(bus.piece),   4);
      chk("skip_preview", 32'(bus5.preview), 32'(9'b011_010_100));

      bus.take = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("stream_piece", 32'(bus.piece), seq_take[k]);
         chk("stream_count", 32'(bus.count), 3);
         chk("stream_valid", 32'(bus.valid), 1);
      end

      bus.seed_we = 1'b1;
      bus.seed_in = 3'b110;
      tick();
      chk("flush_count",   32'(bus.count),   0);
      chk("flush_valid",   32'(bus.valid),   0);
      chk("flush_preview", 32'(bus.preview), 0);
      bus.seed_we = 1'b0;
      bus.take    = 1'b0;
      tick();
      chk("reseed_count", 32'(bus.count), 1);
      chk("reseed_piece", 32'(bus.piece), 5);

      bus.seed_we = 1'b1;
      bus.seed_in = 3'b000;
      tick();
      bus.seed_we = 1'b0;
      bus.take    = 1'b1;
      tick();
      chk("empty_take_count", 32'(bus.count), 1);
      chk("zero_seed_piece",  32'(bus.piece), 4);
      bus.take = 1'b0;
      tick();
      tick();
      chk("zero_seed_preview", 32'(bus.preview), 32'(9'b110_010_100));

      bus.seed_we = 1'b1;
      tick();
      bus.seed_we = 1'b0;
      tick();
      tick();
      chk("pre_rst_count", 32'(bus.count), 2);
      reset_n  = 1'b0;
      bus.take = 1'b1;
      tick();
      chk("mid_rst_count", 32'(bus.count), 0);
      chk("mid_rst_piece", 32'(bus.piece), 0);
      chk("mid_rst_valid", 32'(bus.valid), 0);
      reset_n  = 1'b1;
      bus.take = 1'b0;
      tick();
      chk("post_rst_piece", 32'(bus.piece), 4);
      chk("post_rst_count", 32'(bus.count), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/piece_queue_gen.md
PIECE_QUEUE_GEN -- requirements
Module: piece_queue_gen

Interface
REQ-001 Parameter WIDTH, default 3: LFSR and symbol width in bits, 3..8.
REQ-002 Parameter TAPS, default 3'b110: feedback tap mask, WIDTH bits.
REQ-003 Parameter SEED, default 3'b101: nonzero LFSR reset/restart value.
REQ-004 Parameter DEPTH, default 3: preview queue depth, 1..8.
REQ-005 Parameter NUM_SYMBOLS, default 7: symbols 0..NUM_SYMBOLS-1 are legal; NUM_SYMBOLS <= 2**WIDTH-1.
REQ-006 Clk  input  1: single clock; all state changes on its rising edge.
REQ-007 reset_n  input  1: synchronous, active-low reset.
REQ-008 take  input  1: consumer pops the head symbol this cycle.
REQ-009 seed_we  input  1: load a new seed and flush the queue.
REQ-010 seed_in  input  WIDTH: seed value used when seed_we=1.
REQ-011 piece  output  WIDTH: head-of-queue symbol.
REQ-012 valid  output  1: queue holds at least one symbol.
REQ-013 preview  output  DEPTH*WIDTH: queue entries, head in bits [WIDTH-1:0], unused slots zero.
REQ-014 count  output  4: number of entries held, 0..DEPTH.

Function
REQ-015 LFSR state s SHALL advance as next = {s[WIDTH-2:0], ^(s & TAPS)}.
REQ-016 Candidate symbol SHALL be s-1 (WIDTH-bit subtraction); candidate is accepted iff it is < NUM_SYMBOLS.
REQ-017 Each cycle, with no seed_we: pop = take & valid; space = (count < DEPTH) | pop.
REQ-018 If space and candidate accepted: push candidate at tail and advance s.
REQ-019 If candidate rejected: advance s, no push, regardless of space (rejection skip costs one cycle).
REQ-020 If no space and candidate accepted: s and queue hold.
REQ-021 Pop SHALL shift entries toward head; simultaneous pop and push when full keeps count=DEPTH, new symbol at tail.
REQ-022 take with valid=0 SHALL be ignored.
REQ-023 count next = count + push - pop; piece and preview reflect registered queue contents (one-cycle latency from push to visibility).
REQ-024 valid SHALL equal (count != 0).
REQ-025 If s is ever 0, next s SHALL be SEED (lock-up escape), no push that cycle.
REQ-026 seed_we=1 SHALL set s = seed_in (SEED if seed_in==0), count=0, all entries zero; take ignored; seed_we has priority over push/pop.
REQ-027 With default parameters the generator SHALL emit period-7 sequence 4,2,6,5,3,0,1 from SEED.

Reset
REQ-028 reset_n=0 at a clock edge SHALL set s=SEED, count=0, all queue entries 0, so piece=0, valid=0, preview=0.
REQ-029 reset_n SHALL take priority over seed_we and take; reset mid-fill discards all queued symbols.
REQ-030 Filling SHALL begin on the first edge with reset_n=1.

Verification
REQ-031 Reset release, take=0, defaults -> after edges 1,2,3: count=1,2,3; preview={6,2,4} (tail..head); piece=4; then count holds 3, s holds 3'b110.
REQ-032 Full queue, take=1 continuously -> piece sequence 4,2,6,5,3,0,1,4,... one per cycle, count stays 3, valid stays 1.
REQ-033 NUM_SYMBOLS=5, seed 3'b101, take=0 -> queue receives 4,2,3 (symbols 6,5 skipped); count reaches 3 on edge 5.
REQ-034 Full queue, seed_we=1, seed_in=3'b110, take=1 same cycle -> next cycle count=0, valid=0, preview=0; following edge pushes symbol 5.
REQ-035 seed_we=1, seed_in=0 -> s=3'b101, subsequent sequence identical to post-reset sequence.
REQ-036 reset_n=0 asserted with count=2 and take=1 -> next cycle count=0, piece=0, valid=0; first push after release is 4.
